// File: rtl/seg_scan_driver_if.sv
// Shadow-update bus for seg_scan_driver: display content
// plus the upd_valid/upd_ack handshake.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8,
    parameter int PWM_BITS   = 4
);
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   enable;
    logic [NUM_DIGITS-1:0]   blink;
    logic [NUM_DIGITS-1:0]   dp;
    logic [PWM_BITS-1:0]     brightness;
    logic                    upd_valid;
    logic                    upd_ack;

    modport master (
        output data, enable, blink, dp, brightness, upd_valid,
        input  upd_ack
    );

    modport slave (
        input  data, enable, blink, dp, brightness, upd_valid,
        output upd_ack
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with tear-free shadow
// registers, PWM brightness, anti-ghost blanking and blink.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV_BITS     = 10,
    parameter int PWM_BITS     = 4,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_driver_if.slave      upd,
    output logic [NUM_DIGITS-1:0] cat,
    output logic [7:0]            seg
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FR_W-1:0]     LAST_FR  = FR_W'(BLINK_FRAMES - 1);
    localparam logic [DIV_BITS-1:0] BLANK_V  = DIV_BITS'(BLANK_CYC);

    logic [DIV_BITS-1:0]     div_cnt;
    logic [IDX_W-1:0]        idx;
    logic [FR_W-1:0]         frame_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] sh_data;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [PWM_BITS-1:0]     sh_bright;

    logic                    slot_end;
    logic                    frame_end;
    logic                    load;
    logic [PWM_BITS-1:0]     phase;
    logic                    pwm_on;
    logic                    lit;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   cat_d;
    logic [7:0]              seg_d;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign slot_end  = &div_cnt;
    assign frame_end = slot_end && (idx == LAST_IDX);
    assign load      = frame_end && upd.upd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (slot_end)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (frame_end) begin
                if (frame_cnt == LAST_FR) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Shadows change only on the frame boundary edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data     <= '0;
            sh_en       <= '0;
            sh_blink    <= '0;
            sh_dp       <= '0;
            sh_bright   <= '0;
            upd.upd_ack <= 1'b0;
        end else begin
            upd.upd_ack <= load;
            if (load) begin
                sh_data   <= upd.data;
                sh_en     <= upd.enable;
                sh_blink  <= upd.blink;
                sh_dp     <= upd.dp;
                sh_bright <= upd.brightness;
            end
        end
    end

    always_comb begin
        phase  = div_cnt[DIV_BITS-1 -: PWM_BITS];
        pwm_on = (&sh_bright) || (phase < sh_bright);
        nib    = sh_data[idx*4 +: 4];
        lit    = sh_en[idx] && (div_cnt >= BLANK_V) && pwm_on &&
                 !(sh_blink[idx] && blink_phase);
        cat_d  = '1;
        seg_d  = 8'h00;
        if (lit) begin
            cat_d = ~(NUM_DIGITS'(1) << idx);
            seg_d = {sh_dp[idx], decode(nib)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cat <= '1;
            seg <= 8'h00;
        end else begin
            cat <= cat_d;
            seg <= seg_d;
        end
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
Parameters (name, default, meaning):
REQ-001 NUM_DIGITS, 8, number of multiplexed digits; legal range 1..16.
REQ-002 DIV_BITS, 10, width of the slot counter; each digit slot lasts 2**DIV_BITS clocks.
REQ-003 PWM_BITS, 4, brightness resolution; PWM_BITS <= DIV_BITS.
REQ-004 BLANK_CYC, 16, anti-ghost dark cycles at the start of each slot; BLANK_CYC < 2**DIV_BITS.
REQ-005 BLINK_FRAMES, 64, frames per blink half-period; must be >= 1.

Ports (name, direction, width, meaning):
REQ-006 clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 data  in  4*NUM_DIGITS  hex nibble per digit; digit i = data[4i+3:4i].
REQ-009 enable  in  NUM_DIGITS  per-digit display enable.
REQ-010 blink  in  NUM_DIGITS  per-digit blink enable.
REQ-011 dp  in  NUM_DIGITS  per-digit decimal point.
REQ-012 brightness  in  PWM_BITS  global duty; 0 = dark, all-ones = full.
REQ-013 upd_valid  in  1  request to load data/enable/blink/dp/brightness into shadow registers; held until acknowledged.
REQ-014 upd_ack  out  1  one-cycle pulse: shadow load performed.
REQ-015 cat  out  NUM_DIGITS  cathode select, active-low, at most one bit low.
REQ-016 seg  out  8  segments, active-high; seg[0]=a .. seg[6]=g, seg[7]=dp.

Function
REQ-017 div_cnt (DIV_BITS) shall increment every clock and wrap from 2**DIV_BITS-1 to 0.
REQ-018 Digit index idx shall advance when div_cnt wraps, 0..NUM_DIGITS-1, wrapping to 0.
REQ-019 Frame boundary = cycle with div_cnt all-ones and idx == NUM_DIGITS-1.
REQ-020 At a frame boundary with upd_valid=1, all shadow registers shall load from inputs on that edge and upd_ack shall be 1 in the following cycle only.
REQ-021 upd_valid rising during the boundary cycle itself shall be accepted on that boundary; upd_valid outside a boundary shall not be acknowledged until the next boundary.
REQ-022 If upd_valid remains high after upd_ack, it shall be accepted again at the next boundary (source drops it on ack).
REQ-023 Display shall use shadow registers only; live inputs never reach cat/seg directly (tear-free frames).
REQ-024 phase = div_cnt[DIV_BITS-1 -: PWM_BITS]; pwm_on = (brightness all-ones) or (phase < brightness).
REQ-025 blink_phase shall toggle after every BLINK_FRAMES frame boundaries, via a frame counter wrapping at BLINK_FRAMES-1.
REQ-026 lit = shadow enable[idx] and div_cnt >= BLANK_CYC and pwm_on and not (shadow blink[idx] and blink_phase).
REQ-027 cat and seg shall be registered, reflecting idx/div_cnt of the previous cycle (one-clock latency).
REQ-028 When lit: cat = all ones except bit idx = 0; seg[6:0] = decode(nibble), seg[7] = shadow dp[idx].
REQ-029 When not lit: cat = all ones, seg = 8'h00.
REQ-030 Decode (seg[6:0], hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-031 NUM_DIGITS=1 shall be legal; idx stays 0 and every slot end is a frame boundary.

Reset
REQ-032 rst_n low shall immediately force: div_cnt=0, idx=0, frame counter=0, blink_phase=0, all shadow registers=0, cat=all ones, seg=8'h00, upd_ack=0.
REQ-033 Reset asserted mid-frame or mid-handshake shall discard the pending update; after release, scanning restarts at digit 0, slot cycle 0.

Verification
REQ-034 NUM_DIGITS=8, DIV_BITS=4, BLANK_CYC=2, brightness=F, enable=FF, data=32'h76543210, upd_valid held -> upd_ack one cycle after first boundary; next frame cat[0]=0 with seg=3F, cat[7]=0 with seg=07, dark for 2 cycles at each slot start.
REQ-035 Change data mid-frame without upd_valid -> displayed digits unchanged indefinitely.
REQ-036 brightness=4, PWM_BITS=4, DIV_BITS=4, BLANK_CYC=0 -> each digit lit exactly 4 of 16 slot cycles; brightness=0 -> cat all ones permanently.
REQ-037 BLINK_FRAMES=2, blink=8'h01 -> digit 0 dark for 2 frames, lit for 2 frames, repeating; other digits always lit.
REQ-038 dp=8'h80, data nibble 7 = 8 -> seg=8'hFF during digit 7 slot.
REQ-039 Assert rst_n low mid-slot of digit 5 with upd_valid high -> cat=all ones, seg=0, upd_ack=0 immediately; after release, first lit slot is digit 0 only after the next acknowledged update.
